// File: rtl/buck_pwm_ctrl_if.sv
// Duty-command handshake between the closed-loop controller and buck_pwm_ctrl.
interface buck_pwm_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [CNT_WIDTH-1:0] duty_cmd;
  logic                 duty_valid;
  logic                 duty_ready;

  modport master (output duty_cmd, output duty_valid, input duty_ready);
  modport slave  (input duty_cmd, input duty_valid, output duty_ready);
endinterface

// File: rtl/buck_pwm_ctrl.sv
// Run-time programmable PWM modulator for the buck stage: boundary-applied duty commands,
// min-on/min-off clamping, soft-start and a mid-on-time current-sense strobe.
module buck_pwm_ctrl #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PERIOD    = 200,
  parameter int unsigned MIN_ON    = 2,
  parameter int unsigned MIN_OFF   = 2,
  parameter int unsigned SS_STEP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  buck_pwm_ctrl_if.slave       duty_if,
  output logic                 gate,
  output logic                 period_start,
  output logic                 sample,
  output logic [CNT_WIDTH-1:0] duty_active,
  output logic                 ss_done
);

  localparam int unsigned XW = CNT_WIDTH + 1;
  typedef logic [XW-1:0] ext_t;
  localparam ext_t PeriodX = ext_t'(PERIOD);
  localparam ext_t LastX   = ext_t'(PERIOD - 1);
  localparam ext_t MinOnX  = ext_t'(MIN_ON);
  localparam ext_t MaxOnX  = ext_t'(PERIOD - MIN_OFF);
  localparam ext_t StepX   = ext_t'(SS_STEP);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] pending_q, pending_d;
  logic [CNT_WIDTH-1:0] cmd_q, cmd_d;
  logic [CNT_WIDTH-1:0] ss_limit_q, ss_limit_d;
  logic [CNT_WIDTH-1:0] duty_eff_q, duty_eff_d;
  logic                 pending_full_q, pending_full_d;
  logic                 run_q;
  logic                 ready_q, gate_q, period_start_q, sample_q, ss_done_q;
  logic                 gate_d, sample_d, ss_done_d;
  logic                 accept, boundary;
  ext_t                 ss_sum, m;

  always_comb begin
    accept   = duty_if.duty_valid && ready_q;
    // run_q low means this is the first enabled edge, which starts a fresh period.
    boundary = en && (!run_q || ({1'b0, cnt_q} == LastX));

    cnt_d = '0;
    if (en && !boundary) cnt_d = cnt_q + CNT_WIDTH'(1);

    pending_d      = accept ? duty_if.duty_cmd : pending_q;
    pending_full_d = pending_full_q;
    cmd_d          = cmd_q;
    if (boundary && pending_full_q) begin
      cmd_d          = pending_q;
      pending_full_d = 1'b0;
    end
    if (accept) pending_full_d = 1'b1;

    ss_sum     = {1'b0, ss_limit_q} + StepX;
    ss_limit_d = ss_limit_q;
    duty_eff_d = duty_eff_q;
    m          = '0;
    if (!en) begin
      ss_limit_d = '0;
      duty_eff_d = '0;
    end else if (boundary) begin
      ss_limit_d = (ss_sum > PeriodX) ? PeriodX[CNT_WIDTH-1:0] : ss_sum[CNT_WIDTH-1:0];
      m = ({1'b0, cmd_d} < {1'b0, ss_limit_d}) ? {1'b0, cmd_d} : {1'b0, ss_limit_d};
      if (m == '0)          duty_eff_d = '0;
      else if (m < MinOnX)  duty_eff_d = MinOnX[CNT_WIDTH-1:0];
      else if (m > MaxOnX)  duty_eff_d = MaxOnX[CNT_WIDTH-1:0];
      else                  duty_eff_d = m[CNT_WIDTH-1:0];
    end

    // Outputs are computed from next-state so the flops line up with cnt.
    gate_d    = cnt_d < duty_eff_d;
    sample_d  = en && (duty_eff_d != '0) && (cnt_d == (duty_eff_d >> 1));
    ss_done_d = ({1'b0, ss_limit_d} == PeriodX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      cmd_q          <= '0;
      ss_limit_q     <= '0;
      duty_eff_q     <= '0;
      run_q          <= 1'b0;
      ready_q        <= 1'b1;
      gate_q         <= 1'b0;
      period_start_q <= 1'b0;
      sample_q       <= 1'b0;
      ss_done_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      cmd_q          <= cmd_d;
      ss_limit_q     <= ss_limit_d;
      duty_eff_q     <= duty_eff_d;
      run_q          <= en;
      ready_q        <= !pending_full_d;
      gate_q         <= gate_d;
      period_start_q <= boundary;
      sample_q       <= sample_d;
      ss_done_q      <= ss_done_d;
    end
  end

  assign duty_if.duty_ready = ready_q;
  assign gate               = gate_q;
  assign period_start       = period_start_q;
  assign sample             = sample_q;
  assign duty_active        = duty_eff_q;
  assign ss_done            = ss_done_q;

endmodule

// File: tb/tb_buck_pwm_ctrl.sv
// Directed bench for buck_pwm_ctrl: per-period vector table plus handshake, reset and
// enable-drop sequences.
module tb_buck_pwm_ctrl;
  localparam int unsigned W = 16;
  localparam int Per  = 200;
  localparam int Step = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         gate, period_start, sample, ss_done;
  logic [W-1:0] duty_active;
  int           n_checks = 0;
  int           n_pass   = 0;

  typedef struct {
    bit           send;
    logic [W-1:0] cmd;
    int           exp_on;
    int           exp_ss;
  } vec_t;
  vec_t vecs[15];

  buck_pwm_ctrl_if #(.CNT_WIDTH(W)) duty_if ();

  buck_pwm_ctrl #(
    .CNT_WIDTH(W), .PERIOD(Per), .MIN_ON(2), .MIN_OFF(2), .SS_STEP(Step)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .duty_if     (duty_if),
    .gate        (gate),
    .period_start(period_start),
    .sample      (sample),
    .duty_active (duty_active),
    .ss_done     (ss_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_ps(input string name);
    int t = 0;
    while (period_start !== 1'b1 && t < 2 * Per) begin
      @(negedge clk);
      t++;
    end
    check({name, " period_start seen"}, int'(period_start === 1'b1), 1);
  endtask

  // Called at the negedge of a cnt=0 cycle; returns at the next period's cnt=0 negedge.
  task automatic measure_period(input string name, input bit send, input logic [W-1:0] cmd,
                                input int exp_on, input int exp_ss);
    int on = 0, fall = -1, glitch = 0, ns = 0, spos = -1, nps = 0, rdy11 = -1;
    int ps0, dact, ss;
    ps0  = int'(period_start);
    dact = int'(duty_active);
    ss   = int'(ss_done);
    for (int k = 0; k < Per; k++) begin
      if (gate) begin
        on++;
        if (fall >= 0) glitch++;
      end else if (fall < 0) begin
        fall = k;
      end
      if (sample) begin ns++; spos = k; end
      if (period_start) nps++;
      if (k == 11) rdy11 = int'(duty_if.duty_ready);
      if (send && k == 10) begin
        duty_if.duty_valid = 1'b1;
        duty_if.duty_cmd   = cmd;
      end
      if (k == 11) duty_if.duty_valid = 1'b0;
      @(negedge clk);
    end
    check({name, " period_start@0"}, ps0, 1);
    check({name, " period_start count"}, nps, 1);
    check({name, " on-time"}, on, exp_on);
    check({name, " gate contiguous"}, glitch, 0);
    check({name, " duty_active"}, dact, exp_on);
    check({name, " ss_done"}, ss, exp_ss);
    check({name, " sample count"}, ns, (exp_on != 0) ? 1 : 0);
    if (exp_on != 0) check({name, " sample position"}, spos, exp_on >> 1);
    check({name, " ready after write"}, rdy11, send ? 0 : 1);
  endtask

  initial begin
    int act;
    vecs[0]  = '{1'b0, 16'd0,   20,  0};
    vecs[1]  = '{1'b0, 16'd0,   40,  0};
    vecs[2]  = '{1'b0, 16'd0,   60,  0};
    vecs[3]  = '{1'b0, 16'd0,   80,  0};
    vecs[4]  = '{1'b0, 16'd0,   100, 0};
    vecs[5]  = '{1'b0, 16'd0,   100, 0};
    vecs[6]  = '{1'b0, 16'd0,   100, 0};
    vecs[7]  = '{1'b0, 16'd0,   100, 0};
    vecs[8]  = '{1'b0, 16'd0,   100, 0};
    vecs[9]  = '{1'b1, 16'd0,   100, 1};
    vecs[10] = '{1'b1, 16'd1,   0,   1};
    vecs[11] = '{1'b1, 16'd199, 2,   1};
    vecs[12] = '{1'b1, 16'd500, 198, 1};
    vecs[13] = '{1'b1, 16'd100, 198, 1};
    vecs[14] = '{1'b0, 16'd0,   100, 1};

    rst = 1'b0;
    en  = 1'b0;
    duty_if.duty_valid = 1'b0;
    duty_if.duty_cmd   = '0;
    repeat (3) @(negedge clk);
    check("reset gate", int'(gate), 0);
    check("reset period_start", int'(period_start), 0);
    check("reset sample", int'(sample), 0);
    check("reset duty_active", int'(duty_active), 0);
    check("reset ss_done", int'(ss_done), 0);
    check("reset duty_ready", int'(duty_if.duty_ready), 1);

    rst = 1'b1;
    act = 0;
    for (int k = 0; k < 1000; k++) begin
      if (gate || period_start || sample || ss_done || duty_active != '0) act++;
      @(negedge clk);
    end
    check("idle activity", act, 0);
    check("idle duty_ready", int'(duty_if.duty_ready), 1);

    // Queue a command while disabled; it must wait for the first boundary.
    duty_if.duty_valid = 1'b1;
    duty_if.duty_cmd   = 16'd100;
    @(negedge clk);
    duty_if.duty_valid = 1'b0;
    check("queued ready low", int'(duty_if.duty_ready), 0);
    @(negedge clk);
    check("disabled gate", int'(gate), 0);
    en = 1'b1;
    @(negedge clk);
    check("enable ready back", int'(duty_if.duty_ready), 1);
    check("enable gate", int'(gate), 1);

    for (int i = 0; i < 15; i++)
      measure_period($sformatf("vec%0d", i), vecs[i].send, vecs[i].cmd,
                     vecs[i].exp_on, vecs[i].exp_ss);

    // Handshake: write at cnt=30, hold valid with a second value.
    repeat (30) @(negedge clk);
    duty_if.duty_valid = 1'b1;
    duty_if.duty_cmd   = 16'd60;
    @(negedge clk);
    check("hs ready low", int'(duty_if.duty_ready), 0);
    duty_if.duty_cmd = 16'd80;
    wait_ps("hs 60");
    check("hs ready at boundary", int'(duty_if.duty_ready), 1);
    check("hs duty 60", int'(duty_active), 60);
    @(negedge clk);
    duty_if.duty_valid = 1'b0;
    check("hs 80 accepted", int'(duty_if.duty_ready), 0);
    wait_ps("hs 80");
    check("hs duty 80", int'(duty_active), 80);
    check("hs ready after 80", int'(duty_if.duty_ready), 1);
    // Write on the last cycle of the period: applies two boundaries later.
    repeat (199) @(negedge clk);
    duty_if.duty_valid = 1'b1;
    duty_if.duty_cmd   = 16'd120;
    @(negedge clk);
    duty_if.duty_valid = 1'b0;
    check("late write at boundary", int'(period_start), 1);
    check("late write not applied", int'(duty_active), 80);
    check("late write ready low", int'(duty_if.duty_ready), 0);
    @(negedge clk);
    wait_ps("late");
    check("late write applied", int'(duty_active), 120);
    check("late write ready", int'(duty_if.duty_ready), 1);

    // Asynchronous reset in the middle of the on-time.
    repeat (50) @(negedge clk);
    check("pre-reset gate", int'(gate), 1);
    #2 rst = 1'b0;
    #1;
    check("async reset gate", int'(gate), 0);
    check("async reset duty_active", int'(duty_active), 0);
    check("async reset ready", int'(duty_if.duty_ready), 1);
    check("async reset ss_done", int'(ss_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    measure_period("post-reset p0", 1'b1, 16'd100, 0, 0);
    measure_period("post-reset p1", 1'b0, 16'd0, 40, 0);
    measure_period("post-reset p2", 1'b0, 16'd0, 60, 0);

    // One-cycle enable drop restarts soft-start.
    repeat (5) @(negedge clk);
    check("pre-drop gate", int'(gate), 1);
    en = 1'b0;
    @(negedge clk);
    check("drop gate", int'(gate), 0);
    check("drop duty_active", int'(duty_active), 0);
    check("drop period_start", int'(period_start), 0);
    en = 1'b1;
    @(negedge clk);
    check("re-enable gate", int'(gate), 1);
    measure_period("restart p0", 1'b0, 16'd0, 20, 0);
    measure_period("restart p1", 1'b0, 16'd0, 40, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/buck_pwm_ctrl.md
# buck_pwm_ctrl

- Synthesizable digital PWM modulator that generates the `gate` drive for the `buck` power-stage model.
- Replaces the free-running `PWM` macro so duty cycle can be commanded at run time.
- Duty commands come from a closed-loop controller through a valid/ready handshake and apply only at PWM period boundaries.
- Adds min-on/min-off clamping, soft-start, and a mid-on-time `sample` strobe for current sensing.

## Interface

**Parameters**
- `CNT_WIDTH`, default 16: width of the period counter and of all duty values.
- `PERIOD`, default 200: PWM period in clk cycles (200 cycles = 500 kHz at 100 MHz). Legal range: 4 ≤ PERIOD ≤ 2^CNT_WIDTH−1.
- `MIN_ON`, default 2: minimum non-zero on-time, in cycles.
- `MIN_OFF`, default 2: minimum off-time per period, in cycles. Constraint: MIN_ON + MIN_OFF < PERIOD.
- `SS_STEP`, default 1: soft-start limit increment per period. Must be ≥ 1.

**Ports** (one clock; reset is asynchronous, active-low)
- `clk`, input, 1: system clock, rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: modulator enable.
- `duty_cmd`, input, CNT_WIDTH: commanded on-time, in cycles.
- `duty_valid`, input, 1: `duty_cmd` valid.
- `duty_ready`, output, 1: pending slot empty; command can be accepted.
- `gate`, output, 1: high-side switch drive.
- `period_start`, output, 1: one-cycle pulse in the first cycle of each period.
- `sample`, output, 1: one-cycle pulse at mid on-time.
- `duty_active`, output, CNT_WIDTH: effective on-time of the current period.
- `ss_done`, output, 1: soft-start limit has saturated.

## Operation

**Registers**
- `cnt`: period counter.
- `pending` + `pending_full`: one-entry command buffer.
- `cmd_reg`: last applied command.
- `ss_limit`: soft-start limit.
- `duty_eff`: effective on-time, driven onto `duty_active`.

**Handshake**
- `duty_ready` = !pending_full, registered.
- On a cycle with `duty_valid` && `duty_ready`, `duty_cmd` is written to `pending` and `pending_full` sets.
- A new command never bypasses `pending`: a command accepted on the boundary cycle applies at the following boundary.

**Counter**
- While `en`=1, `cnt` counts 0 … PERIOD−1 and wraps.
- While `en`=0, `cnt` is held at 0.

**Boundary event**
- Occurs on any edge that produces a cycle with `cnt`=0 while `en`=1: either a wrap from PERIOD−1, or the first edge with `en`=1 after `en`=0.
- At this edge, in order:
  - `ss_limit` ← min(ss_limit + SS_STEP, PERIOD), saturating.
  - If `pending_full`: `cmd_reg` ← `pending` and `pending_full` clears.
  - m = min(cmd_reg, ss_limit), using the new values.
  - `duty_eff` ← 0 if m = 0; MIN_ON if 0 < m < MIN_ON; PERIOD−MIN_OFF if m > PERIOD−MIN_OFF; otherwise m.
- Compare at CNT_WIDTH+1 bits so `ss_limit` + SS_STEP cannot wrap.

**Outputs**
- `gate` is registered and aligned with `cnt`: in the cycle where cnt = k, gate = en && (k < duty_eff). It must be glitch-free.
- `sample` = 1 in the cycle where cnt = duty_eff>>1, only when duty_eff ≠ 0.
- `period_start` = 1 in every cycle with cnt = 0 while `en`=1.
- `ss_done` = (ss_limit == PERIOD).

**Disable**
- Edge with `en`=0: `cnt`, `gate`, `duty_eff`, `ss_limit` and `ss_done` go to 0.
- `pending` and `cmd_reg` are retained.

**Reset**
- `rst`=0 clears all registers immediately, without waiting for a clock edge.
- Output values during and after reset: gate=0, period_start=0, sample=0, duty_active=0, ss_done=0, duty_ready=1.
- `cmd_reg`=0 and `pending_full`=0.

## Timing

- Command latency: a value accepted in period n appears on `duty_active` in the first cycle of period n+1. If it is accepted in the last cycle of period n, it appears in period n+2.
- `duty_ready` falls in the cycle after acceptance and rises in the first cycle of the next period (cnt=0).
- After `en` rises: `period_start`=1 and `gate`=(duty_eff>0) in the cycle after the enabling edge.
- After `en` falls: `gate`=0 in the cycle after the disabling edge.
- Reset release: the first edge with `rst`=1 may start a period if `en`=1.

## Test plan

1. **Reset/idle.** rst=0, then released with en=0, duty_valid=0 → gate=0, duty_ready=1, duty_active=0, ss_done=0, no pulses for 1000 cycles.
2. **Steady 50%.** PERIOD=200, SS_STEP=200, duty_cmd=100 accepted, then en=1 → gate high exactly 100 cycles then low 100 cycles, repeating; period_start every 200 cycles; sample at cnt=50; duty_active=100.
3. **Clamp.** Commands 0, 1, 199, 500 in successive periods → on-times 0 (no sample pulse), 2, 198, 198.
4. **Soft-start.** SS_STEP=20, cmd=100 → per-period on-times 20, 40, 60, 80, 100, 100, …; ss_done rises at the 10th boundary (ss_limit=200). Dropping en for 1 cycle restarts the sequence at 20.
5. **Handshake.** Write 60 at cnt=30; hold valid with 80 → duty_ready=0 until cnt=0; 60 becomes active there; 80 is accepted at cnt=0 and becomes active one period later. A write on the cnt=199 cycle applies two boundaries later.
6. **Async reset mid-operation.** rst=0 asynchronously at cnt=50 while gate=1 → gate=0 before the next edge; after release with en=1, soft-start restarts from SS_STEP and cmd_reg=0 gives on-time 0 until a new command is accepted.
